// File: rtl/pbs_rng_pkg.sv
// Shared constants, sampler state encoding and the rejection-limit helper
// for the pseudo-random sampling blocks.
package pbs_rng_pkg;

    localparam int unsigned LFSR_W = 13;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        REDUCE,
        DONE
    } sampler_state_t;

    // Largest multiple of range that fits in an in_w-bit word.
    function automatic int unsigned calc_limit(input int unsigned range,
                                               input int unsigned in_w);
        return ((32'd1 << in_w) / range) * range;
    endfunction

endpackage

// File: rtl/rnd_mod_reducer.sv
// Fixed-latency restoring remainder: i_sample mod RANGE over IN_W cycles,
// MSB first. The first step happens on the start cycle itself.
module rnd_mod_reducer #(
    parameter int unsigned IN_W  = 13,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned RANGE = 100
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [IN_W-1:0]  i_sample,
    output logic             o_busy,
    output logic             o_done,
    output logic [OUT_W-1:0] o_remainder
);

    localparam int unsigned      CNT_W   = $clog2(IN_W + 1);
    localparam logic [OUT_W+1:0] RANGE_C = (OUT_W + 2)'(RANGE);

    logic [IN_W-1:0]  r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W:0]   r_rem;
    logic             r_busy;
    logic             r_done;

    logic [OUT_W:0]   w_rem_src;
    logic             w_bit;
    logic [OUT_W+1:0] w_cat;
    logic [OUT_W:0]   w_sub;
    logic [OUT_W:0]   w_next;

    assign w_rem_src = i_start ? '0 : r_rem;
    assign w_bit     = i_start ? i_sample[IN_W-1] : r_shift[IN_W-1];
    assign w_cat     = {w_rem_src, w_bit};
    // w_cat < 2*RANGE <= 2^(OUT_W+1), so the subtraction fits in OUT_W+1 bits.
    assign w_sub     = w_cat[OUT_W:0] - RANGE_C[OUT_W:0];
    assign w_next    = (w_cat >= RANGE_C) ? w_sub : w_cat[OUT_W:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem   <= w_next;
                r_shift <= i_sample << 1;
                r_cnt   <= CNT_W'(IN_W - 1);
                if (IN_W == 1) begin
                    r_done <= 1'b1;
                end else begin
                    r_busy <= 1'b1;
                end
            end else if (r_busy) begin
                r_rem   <= w_next;
                r_shift <= r_shift << 1;
                r_cnt   <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_remainder = r_rem[OUT_W-1:0];

endmodule

// File: rtl/rnd_range_sampler.sv
// Unbiased [0, RANGE-1] sampler over LFSR words via rejection + remainder.
// Optional reject_count output when RND_SAMPLER_STATS_EN is defined.
module rnd_range_sampler
    import pbs_rng_pkg::*;
#(
    parameter int unsigned IN_W      = LFSR_W,
    parameter int unsigned OUT_W     = 8,
    parameter int unsigned RANGE     = 100,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [IN_W-1:0]  rnd_in,
    input  logic             rnd_strobe,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_value,
    output logic             out_fallback
`ifdef RND_SAMPLER_STATS_EN
    ,
    output logic [15:0]      reject_count
`endif
);

    localparam int unsigned   LIMIT   = calc_limit(RANGE, IN_W);
    localparam logic [IN_W:0] LIMIT_C = (IN_W + 1)'(LIMIT);
    localparam logic [3:0]    MAX_C   = 4'(MAX_TRIES);

    sampler_state_t   r_state;
    logic [3:0]       r_tries;
    logic [IN_W-1:0]  r_sample;
    logic             r_start;
    logic             r_fallback;
    logic             r_req_ready;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_value;
    logic             r_out_fallback;
`ifdef RND_SAMPLER_STATS_EN
    logic [15:0]      r_reject_count;
`endif

    logic             w_below;
    logic [3:0]       w_tries_inc;
    logic             w_busy;
    logic             w_done;
    logic [OUT_W-1:0] w_rem;

    assign w_below     = {1'b0, rnd_in} < LIMIT_C;
    assign w_tries_inc = r_tries + 4'd1;

    rnd_mod_reducer #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .RANGE(RANGE)
    ) u_reducer (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_start    (r_start),
        .i_sample   (r_sample),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_remainder(w_rem)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_tries        <= '0;
            r_sample       <= '0;
            r_start        <= 1'b0;
            r_fallback     <= 1'b0;
            r_req_ready    <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_value    <= '0;
            r_out_fallback <= 1'b0;
`ifdef RND_SAMPLER_STATS_EN
            r_reject_count <= '0;
`endif
        end else begin
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_tries     <= '0;
                        r_state     <= WAIT;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (rnd_strobe) begin
                        r_sample <= rnd_in;
                        r_tries  <= w_tries_inc;
`ifdef RND_SAMPLER_STATS_EN
                        if (!w_below && r_reject_count != 16'hFFFF) begin
                            r_reject_count <= r_reject_count + 16'd1;
                        end
`endif
                        if (w_below) begin
                            r_fallback <= 1'b0;
                            r_start    <= 1'b1;
                            r_state    <= REDUCE;
                        end else if (w_tries_inc == MAX_C) begin
                            r_fallback <= 1'b1;
                            r_start    <= 1'b1;
                            r_state    <= REDUCE;
                        end
                    end
                end
                REDUCE: begin
                    if (w_done && !w_busy) begin
                        r_out_valid    <= 1'b1;
                        r_out_value    <= w_rem;
                        r_out_fallback <= r_fallback;
                        r_state        <= DONE;
                    end
                end
                DONE: begin
                    // req_ready stays low here; IDLE raises it one cycle later.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign out_valid    = r_out_valid;
    assign out_value    = r_out_value;
    assign out_fallback = r_out_fallback;
`ifdef RND_SAMPLER_STATS_EN
    assign reject_count = r_reject_count;
`endif

endmodule

// File: tb/tb_rnd_range_sampler.sv
// Randomized self-checking bench for rnd_range_sampler against a
// behavioural rejection-sampling model (set RND_SAMPLER_STATS_EN for stats).
module tb_rnd_range_sampler;

    localparam int IN_W      = 13;
    localparam int OUT_W     = 8;
    localparam int RANGE     = 100;
    localparam int MAX_TRIES = 8;
    localparam int WMAX      = (1 << IN_W) - 1;
    localparam int LIMIT     = ((1 << IN_W) / RANGE) * RANGE;

    logic             clock;
    logic             reset;
    logic [IN_W-1:0]  rnd_in;
    logic             rnd_strobe;
    logic             req_valid;
    logic             req_ready;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_value;
    logic             out_fallback;
`ifdef RND_SAMPLER_STATS_EN
    logic [15:0]      reject_count;
`endif

    int n_checks;
    int n_errors;
    int q_s[$];
    int exp_rej;

    rnd_range_sampler #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .RANGE    (RANGE),
        .MAX_TRIES(MAX_TRIES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rnd_in      (rnd_in),
        .rnd_strobe  (rnd_strobe),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_value   (out_value),
        .out_fallback(out_fallback)
`ifdef RND_SAMPLER_STATS_EN
        ,
        .reject_count(reject_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Walk the sample list the way the sampler's rules dictate.
    task automatic model(output int n_used, output int val, output int fb);
        n_used = 0;
        val    = 0;
        fb     = 0;
        foreach (q_s[i]) begin
            n_used++;
            if (q_s[i] >= LIMIT && exp_rej < 65535) exp_rej++;
            if (q_s[i] < LIMIT) begin
                val = q_s[i] % RANGE;
                break;
            end
            if (n_used == MAX_TRIES) begin
                val = q_s[i] % RANGE;
                fb  = 1;
                break;
            end
        end
    endtask

    task automatic run_txn(input int hold);
        int n_used, val, fb, lat, w;
        model(n_used, val, fb);
        w = 0;
        while (!req_ready && w < 20) begin
            tick();
            w++;
        end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
            rnd_strobe = 1'b1;
            rnd_in     = IN_W'($urandom_range(0, WMAX));
        end
        tick();
        req_valid  = 1'b0;
        rnd_strobe = 1'b0;
        chk("req_ready_busy", req_ready, 0);
        for (int i = 0; i < n_used; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            rnd_in     = IN_W'(q_s[i]);
            rnd_strobe = 1'b1;
            tick();
            rnd_strobe = 1'b0;
        end
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            rnd_strobe = ($urandom_range(0, 3) == 0);
            rnd_in     = IN_W'($urandom_range(0, WMAX));
            tick();
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        rnd_strobe = 1'b0;
        chk("latency", lat, IN_W + 1);
        chk("out_value", out_value, val);
        chk("out_fallback", out_fallback, fb);
`ifdef RND_SAMPLER_STATS_EN
        chk("reject_count", reject_count, exp_rej);
`endif
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            rnd_strobe = ($urandom_range(0, 1) == 1);
            rnd_in     = IN_W'($urandom_range(0, WMAX));
            tick();
            chk("hold_stable", {out_valid, out_fallback, out_value},
                {1'b1, fb[0], val[OUT_W-1:0]});
        end
        rnd_strobe = 1'b0;
        out_ready  = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("ready_gap", req_ready, 0);
        tick();
        chk("ready_back", req_ready, 1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp_rej    = 0;
        reset      = 1'b0;
        rnd_in     = '0;
        rnd_strobe = 1'b0;
        req_valid  = 1'b0;
        out_ready  = 1'b0;

        tick();
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_value", out_value, 0);
        chk("rst_out_fallback", out_fallback, 0);
        reset = 1'b1;
        tick();
        chk("ready_after_reset", req_ready, 1);

        q_s = '{5};                    run_txn(2);
        q_s = '{7999};                 run_txn(0);
        q_s = '{8099};                 run_txn(1);
        q_s = '{8150, 200};            run_txn(1);
        q_s = '{8191, 8191, 8191, 8191, 8191, 8191, 8191, 8191};
        run_txn(20);

        for (int t = 0; t < 30; t++) begin
            q_s.delete();
            for (int j = 0; j < MAX_TRIES; j++) begin
                if ($urandom_range(0, 3) == 0) q_s.push_back($urandom_range(0, LIMIT - 1));
                else                           q_s.push_back($urandom_range(LIMIT, WMAX));
            end
            run_txn($urandom_range(0, 5));
        end

        // Make sure out_value is nonzero before the mid-REDUCE reset.
        q_s = '{77};                   run_txn(0);
        req_valid = 1'b1;
        tick();
        req_valid  = 1'b0;
        rnd_in     = IN_W'(8191);
        rnd_strobe = 1'b1;
        tick();
        rnd_in     = IN_W'(42);
        tick();
        rnd_strobe = 1'b0;
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        exp_rej = 0;
        chk("async_rst_req_ready", req_ready, 0);
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_out_value", out_value, 0);
        chk("async_rst_out_fallback", out_fallback, 0);
`ifdef RND_SAMPLER_STATS_EN
        chk("async_rst_reject_count", reject_count, 0);
`endif
        tick();
        reset = 1'b1;
        tick();
        chk("ready_after_rerst", req_ready, 1);
        chk("no_stale_valid", out_valid, 0);
        q_s = '{42};                   run_txn(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
